// File: rtl/cic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic_pkg                                                              |
// | Shared constants, bank-select encodings and FSM state encoding.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cic_pkg;

    localparam int CIC_DW        = 20;
    localparam int CIC_AW        = 12;
    localparam int CIC_IMG_DEPTH = 4096;
    localparam int CIC_L1_DEPTH  = 1024;
    localparam int CIC_L2_DEPTH  = 2048;

    localparam logic [2:0] SEL_NSEL = 3'd0;
    localparam logic [2:0] SEL_L0K0 = 3'd1;
    localparam logic [2:0] SEL_L0K1 = 3'd2;
    localparam logic [2:0] SEL_L1K0 = 3'd3;
    localparam logic [2:0] SEL_L1K1 = 3'd4;
    localparam logic [2:0] SEL_L2F  = 3'd5;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READY = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cic_bank_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic_bank_ram                                                         |
// | Simple dual-port synchronous RAM, registered read, read-before-write.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cic_bank_ram #(
    parameter int DEPTH = 1024,
    parameter int DW    = 20,
    parameter int ABITS = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [ABITS-1:0] i_waddr,
    input  logic [DW-1:0]    i_wdata,
    input  logic [ABITS-1:0] i_raddr,
    output logic [DW-1:0]    o_rdata
);

    logic [DW-1:0] r_mem [0:DEPTH-1];

    // Read and write share one block so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/cic_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic_mem_responder                                                    |
// | Image memory, five layer banks and the ready/busy run handshake.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cic_mem_responder
    import cic_pkg::*;
#(
    parameter int DW        = CIC_DW,
    parameter int AW        = CIC_AW,
    parameter int IMG_DEPTH = CIC_IMG_DEPTH,
    parameter int L1_DEPTH  = CIC_L1_DEPTH,
    parameter int L2_DEPTH  = CIC_L2_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          img_we,
    input  logic [AW-1:0] img_addr,
    input  logic [DW-1:0] img_wdata,
    input  logic          start,
    output logic          done,
    output logic          err,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic [2:0]    csel,
    input  logic [2:0]    dbg_sel,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    // Select 0 maps to the image depth so the debug port can reuse this.
    function automatic logic [AW:0] f_depth(input logic [2:0] sel);
        case (sel)
            SEL_NSEL, SEL_L0K0, SEL_L0K1: f_depth = (AW+1)'(IMG_DEPTH);
            SEL_L1K0, SEL_L1K1:           f_depth = (AW+1)'(L1_DEPTH);
            SEL_L2F:                      f_depth = (AW+1)'(L2_DEPTH);
            default:                      f_depth = '0;
        endcase
    endfunction

    state_t r_state;
    state_t w_state_nxt;

    logic w_idle_done, w_ready_run, w_run;
    logic w_rd_legal, w_wr_legal, w_dbg_legal, w_img_we, w_err_set;
    logic [AW-1:0] w_img_raddr, w_lyr_raddr;
    logic [DW-1:0] w_q [0:7];
    logic [DW-1:0] w_idata, w_cdata;

    logic          r_fetch, r_rd_req, r_rd_ok, r_dbg_ok, r_err;
    logic [2:0]    r_rd_sel, r_dbg_sel;
    logic [DW-1:0] r_idata_hold, r_cdata_hold;

    assign w_idle_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_ready_run = (r_state == ST_READY) || (r_state == ST_RUN);
    assign w_run       = (r_state == ST_RUN);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_READY;
            ST_READY: if (busy)  w_state_nxt = ST_RUN;
            ST_RUN:   if (!busy) w_state_nxt = ST_DONE;
            ST_DONE:  if (start) w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_rd_legal  = w_run && (csel != SEL_NSEL) && ({1'b0, caddr_rd} < f_depth(csel));
    assign w_wr_legal  = w_run && (csel != SEL_NSEL) && ({1'b0, caddr_wr} < f_depth(csel));
    assign w_dbg_legal = w_idle_done && ({1'b0, dbg_addr} < f_depth(dbg_sel));
    assign w_img_we    = img_we && w_idle_done && !reset;
    assign w_err_set   = (img_we && w_ready_run) || (crd && !w_rd_legal) || (cwr && !w_wr_legal);

    assign w_img_raddr = w_ready_run ? iaddr    : dbg_addr;
    assign w_lyr_raddr = w_run       ? caddr_rd : dbg_addr;

    for (genvar gi = 0; gi < 8; gi++) begin : g_bank
        localparam int D = int'(f_depth(3'(gi)));
        if (gi == 0) begin : g_img
            localparam int B = $clog2(D);
            cic_bank_ram #(.DEPTH(D), .DW(DW)) u_ram (
                .clk     (clk),
                .i_we    (w_img_we),
                .i_waddr (img_addr[B-1:0]),
                .i_wdata (img_wdata),
                .i_raddr (w_img_raddr[B-1:0]),
                .o_rdata (w_q[gi])
            );
        end else if (D > 0) begin : g_layer
            localparam int B = $clog2(D);
            logic w_we;
            assign w_we = cwr && w_wr_legal && (csel == 3'(gi)) && !reset;
            cic_bank_ram #(.DEPTH(D), .DW(DW)) u_ram (
                .clk     (clk),
                .i_we    (w_we),
                .i_waddr (caddr_wr[B-1:0]),
                .i_wdata (cdata_wr),
                .i_raddr (w_lyr_raddr[B-1:0]),
                .o_rdata (w_q[gi])
            );
        end else begin : g_none
            assign w_q[gi] = '0;
        end
    end

    // RAM outputs update every cycle; the hold registers give idata and
    // cdata_rd their "keep last value" behaviour without extra latency.
    assign w_idata = r_fetch  ? w_q[0] : r_idata_hold;
    assign w_cdata = r_rd_req ? (r_rd_ok ? w_q[r_rd_sel] : '0) : r_cdata_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_fetch      <= 1'b0;
            r_rd_req     <= 1'b0;
            r_rd_ok      <= 1'b0;
            r_rd_sel     <= '0;
            r_dbg_ok     <= 1'b0;
            r_dbg_sel    <= '0;
            r_idata_hold <= '0;
            r_cdata_hold <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch      <= w_ready_run && busy;
            r_rd_req     <= crd;
            r_rd_ok      <= w_rd_legal;
            r_rd_sel     <= csel;
            r_dbg_ok     <= w_dbg_legal;
            r_dbg_sel    <= dbg_sel;
            r_idata_hold <= w_idata;
            r_cdata_hold <= w_cdata;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ready    = (r_state == ST_READY);
    assign done     = (r_state == ST_DONE);
    assign err      = r_err;
    assign idata    = w_idata;
    assign cdata_rd = w_cdata;
    assign dbg_data = r_dbg_ok ? w_q[r_dbg_sel] : '0;

endmodule
`default_nettype wire
